// File: rtl/stoch_bitstream_estimator.sv
// Stochastic bitstream estimator: counts the 1s on 'a' over a window of
// 2^LOG_WINDOW samples and offers the count through a valid/ready handshake.
module stoch_bitstream_estimator #(
    parameter int LOG_WINDOW = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start,
    input  logic                  a,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  est_valid,
    output logic [LOG_WINDOW:0]   est
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [LOG_WINDOW:0] LAST_SAMPLE = (LOG_WINDOW + 1)'((1 << LOG_WINDOW) - 1);

    state_t              state;
    state_t              next_state;
    logic [LOG_WINDOW:0] ones_cnt;
    logic [LOG_WINDOW:0] sample_cnt;
    logic                clear_cnt;
    logic                last_sample;

    // sample_cnt holds the number of samples already taken, so the edge that
    // takes sample W is the one where it equals W-1
    assign last_sample = (sample_cnt == LAST_SAMPLE);

    always_comb begin
        next_state = state;
        clear_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCUM;
                    clear_cnt  = 1'b1;
                end
            end
            ACCUM: begin
                if (last_sample) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        next_state = ACCUM;
                        clear_cnt  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ones_cnt   <= '0;
            sample_cnt <= '0;
        end else if (clear_cnt) begin
            ones_cnt   <= '0;
            sample_cnt <= '0;
        end else if (state == ACCUM) begin
            ones_cnt   <= ones_cnt + {{LOG_WINDOW{1'b0}}, a};
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // Status flags are registered from next_state so outputs never see inputs combinationally
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy      <= 1'b0;
            est_valid <= 1'b0;
            est       <= '0;
        end else begin
            busy      <= (next_state == ACCUM);
            est_valid <= (next_state == HOLD);
            if (state == ACCUM && last_sample) begin
                est <= ones_cnt + {{LOG_WINDOW{1'b0}}, a};
            end
        end
    end

endmodule

// File: tb/tb_stoch_bitstream_estimator.sv
// Scoreboard bench for stoch_bitstream_estimator with LOG_WINDOW=4: directed
// windows push expected counts, a monitor checks est at each accepted handshake.
module tb_stoch_bitstream_estimator;

    localparam int LW = 4;
    localparam int W  = 1 << LW;

    logic          CLK;
    logic          nRST;
    logic          start;
    logic          a;
    logic          out_ready;
    logic          busy;
    logic          est_valid;
    logic [LW:0]   est;

    int total_checks  = 0;
    int passed_checks = 0;
    int exp_q[$];

    stoch_bitstream_estimator #(.LOG_WINDOW(LW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .a         (a),
        .out_ready (out_ready),
        .busy      (busy),
        .est_valid (est_valid),
        .est       (est)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start a window (the start edge may also be a HOLD handshake edge) and
    // feed 'pattern' LSB first; returns just after the edge that should raise est_valid
    task automatic applyStimulus(input logic [W-1:0] pattern, input int expected,
                                 input bit noisy_start);
        start = 1'b1;
        exp_q.push_back(expected);
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            checkOutput("busy_in_window", int'(busy), 1);
            checkOutput("valid_in_window", int'(est_valid), 0);
            a = pattern[i];
            if (noisy_start) start = i[0];
            tick();
        end
        start = 1'b0;
        checkOutput("valid_at_W", int'(est_valid), 1);
        checkOutput("busy_at_W", int'(busy), 0);
    endtask

    always @(negedge CLK) begin
        if (nRST && est_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", int'(est), -1);
            end else begin
                checkOutput("est", int'(est), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] rnd;
        nRST      = 1'b0;
        start     = 1'b0;
        a         = 1'b0;
        out_ready = 1'b1;
        #2;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(est_valid), 0);
        checkOutput("reset_est", int'(est), 0);
        #10 nRST = 1'b1;
        tick();
        tick();

        // a ignored in IDLE
        a = 1'b1;
        tick();
        checkOutput("idle_busy", int'(busy), 0);

        // Full scale, then handshake one cycle later; est is retained afterwards
        applyStimulus(16'hFFFF, 16, 1'b0);
        tick();
        checkOutput("valid_cleared", int'(est_valid), 0);
        checkOutput("est_retained", int'(est), 16);

        applyStimulus(16'h0000, 0, 1'b0);
        tick();
        checkOutput("zero_valid_cleared", int'(est_valid), 0);

        applyStimulus(16'hAAAA, 8, 1'b0);
        tick();

        // Backpressure: hold for 5 cycles, accept on the 6th
        out_ready = 1'b0;
        applyStimulus(16'hFFFF, 16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", int'(est_valid), 1);
            checkOutput("bp_est", int'(est), 16);
            checkOutput("bp_busy", int'(busy), 0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_released_valid", int'(est_valid), 0);
        checkOutput("bp_released_busy", int'(busy), 0);

        // start toggled throughout ACCUM must not restart or stretch the window
        out_ready = 1'b1;
        applyStimulus(16'h00FF, 8, 1'b1);

        // Back-to-back windows: start+out_ready in HOLD restarts immediately
        applyStimulus(16'h1234, 5, 1'b0);
        applyStimulus(16'hF0F1, 9, 1'b0);
        tick();
        checkOutput("b2b_idle", int'(busy), 0);

        // Asynchronous reset mid-window discards the partial count
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 1'b1;
        tick();
        tick();
        #2 nRST = 1'b0;
        #1;
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_valid", int'(est_valid), 0);
        checkOutput("async_est", int'(est), 0);
        #2 nRST = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            checkOutput("post_reset_valid", int'(est_valid), 0);
        end
        applyStimulus(16'h0F0F, 8, 1'b0);
        tick();

        // Random windows against a popcount reference
        for (int n = 0; n < 4; n++) begin
            rnd = W'($urandom);
            applyStimulus(rnd, $countones(rnd), 1'b0);
            tick();
        end

        tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/stoch_bitstream_estimator.md
Name: stoch_bitstream_estimator

Overview:
- Downstream consumer of a stochastic bitstream generator.
- Counts the 1s in the serial bitstream over a fixed window of 2^LOG_WINDOW cycles.
- Presents the count as an unsigned estimate of the stream mean (est / 2^LOG_WINDOW), with a valid/ready output handshake.
- Used to decode stochastic results back to binary and to check generator statistics on the bench.

Parameters:
- LOG_WINDOW, default 8: log2 of window length. W = 1 << LOG_WINDOW. Legal range 1..24.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- start  input  1  request a new estimation window; sampled on rising edge.
- a  input  1  stochastic bitstream input; one bit per cycle.
- out_ready  input  1  consumer accepts est this cycle.
- busy  output  1  high while in ACCUM.
- est_valid  output  1  est holds a completed, unconsumed result.
- est  output  LOG_WINDOW+1  count of 1s in the last completed window, range 0..W.

Behaviour:
- Reset (nRST low, asynchronous, independent of CLK):
  - state=IDLE; busy=0, est_valid=0, est=0.
  - Internal ones counter and sample counter cleared.
  - Reset asserted mid-window discards the partial count; no result is produced.
- State IDLE:
  - busy=0, est_valid=0.
  - Edge with start=1: clear ones counter and sample counter, go to ACCUM.
  - a is ignored in IDLE.
- State ACCUM:
  - busy=1.
  - Every edge samples a; ones counter += a; sample counter += 1.
  - Exactly W samples taken, on W consecutive edges following the start edge.
  - On the edge taking sample W: est <= ones + a (full width, no overflow; max W fits in LOG_WINDOW+1 bits), est_valid <= 1, busy <= 0, go to HOLD.
  - start is ignored during ACCUM; no restart, no queuing.
- State HOLD:
  - est_valid=1; est stable.
  - Edge with out_ready=0: remain; est and est_valid unchanged, indefinitely.
  - Edge with out_ready=1 and start=0: est_valid <= 0, go to IDLE.
  - Edge with out_ready=1 and start=1: est_valid <= 0, clear counters, go to ACCUM (back-to-back window, no idle cycle).
- Timing:
  - start accepted at edge k: samples on edges k+1..k+W.
  - est_valid rises at edge k+W, i.e. latency W cycles from start acceptance to valid.
  - Throughput: one window per W+1 cycles under continuous start and out_ready.
- est after handshake: retains the last value until overwritten by the next completed window (est_valid is the only qualifier).
- out_ready in IDLE or ACCUM has no effect.
- Sample counter is LOG_WINDOW+1 bits or equivalent; compare against W exactly (no wrap-around miscount at W = 2^LOG_WINDOW).
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- LOG_WINDOW=4, a tied 1, start pulse at edge 0, out_ready=1: busy high edges 0..15; est_valid at edge 16 with est=16 (full-scale, MSB set); est_valid clears edge 17.
- LOG_WINDOW=4, a tied 0: est=0, est_valid one cycle. Alternating 1010…: est=8.
- LOG_WINDOW=10, a driven by generator with MEAN=2^30 (p=0.25): est within 256±55 over 20 windows; mean of est within 256±12.
- Backpressure: result est=16, out_ready held 0 for 5 cycles: est_valid stays 1, est stays 16, busy 0; accept on cycle 6 -> IDLE.
- start pulses during ACCUM ignored (count and window length unchanged); start+out_ready together in HOLD -> ACCUM next edge, second est correct, period W+1.
- nRST pulsed low mid-ACCUM (asynchronously, between edges): outputs 0 immediately; after release no est_valid until a new start; following window counts correctly.
